// File: rtl/det_pkg.sv
// det_pkg: shared definitions for the sequential determinant engine.
//   - state_t   : FSM encoding (IDLE, MUL_A, MUL_B, DONE)
//   - MODO_*    : mode select constants carried on the modo input
//   - T_*       : number of product terms per mode
//   - *_3X3 / *_2X2 : Sarrus factor-index tables (x, y, z) and sign vectors
//   - term_info : looks up the factor indices and sign of term k
//   - last_term : index of the final term for a mode
// Element indices 0..8 map to a..i (row-major). Index 9 stands for the
// constant 1, used as the third factor of the 2x2 terms.
package det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_A = 2'd1,
    MUL_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODO_2X2 = 1'b0;
  localparam logic MODO_3X3 = 1'b1;

  localparam int unsigned T_2X2 = 2;
  localparam int unsigned T_3X3 = 6;

  typedef logic [3:0] idx_t;

  localparam idx_t IDX_ONE = 4'd9;

  // Terms: +aei, +bfg, +cdh, -ceg, -afh, -bdi
  localparam idx_t X_3X3 [6] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd0, 4'd1};
  localparam idx_t Y_3X3 [6] = '{4'd4, 4'd5, 4'd3, 4'd4, 4'd5, 4'd3};
  localparam idx_t Z_3X3 [6] = '{4'd8, 4'd6, 4'd7, 4'd6, 4'd7, 4'd8};
  localparam logic [5:0] NEG_3X3 = 6'b111000;

  // Terms: +ae*1, -bd*1
  localparam idx_t X_2X2 [2] = '{4'd0, 4'd1};
  localparam idx_t Y_2X2 [2] = '{4'd4, 4'd3};
  localparam idx_t Z_2X2 [2] = '{IDX_ONE, IDX_ONE};
  localparam logic [1:0] NEG_2X2 = 2'b10;

  typedef struct packed {
    logic neg;
    idx_t x;
    idx_t y;
    idx_t z;
  } term_t;

  // Out-of-range k (never reached by the FSM) yields a harmless zero term.
  function automatic term_t term_info(input logic modo, input logic [2:0] k);
    term_t t;
    t = '0;
    if (modo == MODO_3X3) begin
      if (k < 3'd6) begin
        t.neg = NEG_3X3[k];
        t.x   = X_3X3[k];
        t.y   = Y_3X3[k];
        t.z   = Z_3X3[k];
      end
    end else begin
      if (k < 3'd2) begin
        t.neg = NEG_2X2[k[0]];
        t.x   = X_2X2[k[0]];
        t.y   = Y_2X2[k[0]];
        t.z   = Z_2X2[k[0]];
      end
    end
    return t;
  endfunction

  function automatic logic [2:0] last_term(input logic modo);
    return (modo == MODO_3X3) ? 3'(T_3X3 - 1) : 3'(T_2X2 - 1);
  endfunction

endpackage

// File: rtl/det_mac.sv
// det_mac: shared signed multiply/accumulate datapath.
//   Stage 1 (en_mul): p   <= x * y            (2W-bit signed product register)
//   Stage 2 (en_acc): acc <= acc +/- p * z    (RW-bit signed accumulator)
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clear           : zero the accumulator and product register
//   en_mul, en_acc  : stage enables driven by the control FSM
//   sub             : 1 subtracts p*z from acc, 0 adds it
//   x, y, z         : signed W-bit factors
//   acc             : running signed accumulator
module det_mac #(
  parameter int W  = 8,
  parameter int RW = 3*W+1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en_mul,
  input  logic                 en_acc,
  input  logic                 sub,
  input  logic signed [W-1:0]  x,
  input  logic signed [W-1:0]  y,
  input  logic signed [W-1:0]  z,
  output logic signed [RW-1:0] acc
);

  localparam int PW = 2*W;

  logic signed [PW-1:0] p;
  logic signed [RW-1:0] prod;

  // Operands are sign-extended to the result width before multiplying so the
  // products are exact.
  always_comb begin
    prod = RW'(p) * RW'(z);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      p   <= '0;
      acc <= '0;
    end else begin
      if (en_mul) begin
        p <= PW'(x) * PW'(y);
      end
      if (en_acc) begin
        acc <= sub ? (acc - prod) : (acc + prod);
      end
    end
  end

endmodule

// File: rtl/mod_det_seq.sv
// mod_det_seq: sequential signed determinant engine (2x2 or 3x3).
// One multiplier is time-shared across all Sarrus terms; each term takes
// two cycles (MUL_A then MUL_B), followed by a two-cycle DONE phase whose
// second cycle carries the done pulse and freshly registered results.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start, modo     : operation request and mode (0 = 2x2, 1 = 3x3), sampled in IDLE
//   matriz          : elements a..i, row-major, a at [W-1:0]
//   busy            : high in every state except IDLE
//   done            : one-cycle pulse when results are valid
//   resultado       : W-bit result (wrapped, or saturated when DET_SATURATE_EN)
//   resultado_full  : exact RW-bit signed determinant
//   flag_overflow   : exact result does not fit in signed W bits
// Build option: define DET_SATURATE_EN to saturate resultado on overflow.
module mod_det_seq
  import det_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          modo,
  input  logic [9*W-1:0]                matriz,
  output logic                          busy,
  output logic                          done,
  output logic [W-1:0]                  resultado,
  output logic signed [3*W:0]           resultado_full,
  output logic                          flag_overflow
);

  localparam int RW = 3*W+1;

  localparam logic signed [RW-1:0] MAX_POS = {{(RW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_NEG = {{(RW-W+1){1'b1}}, {(W-1){1'b0}}};

  state_t             state;
  logic [2:0]         k;
  logic [9*W-1:0]     mat_q;
  logic               modo_q;

  term_t              term_cur;
  logic signed [W-1:0] x_sel;
  logic signed [W-1:0] y_sel;
  logic signed [W-1:0] z_sel;
  logic signed [RW-1:0] acc;

  logic               mac_clear;
  logic               mac_en_mul;
  logic               mac_en_acc;

  logic               ovf;
  logic [W-1:0]       res_w;

  function automatic logic signed [W-1:0] pick(input logic [9*W-1:0] m, input idx_t idx);
    if (idx == IDX_ONE) begin
      return {{(W-1){1'b0}}, 1'b1};
    end
    return m[int'(idx)*W +: W];
  endfunction

  // Operand selection for the current term from the captured matrix.
  always_comb begin
    term_cur = term_info(modo_q, k);
    x_sel    = pick(mat_q, term_cur.x);
    y_sel    = pick(mat_q, term_cur.y);
    z_sel    = pick(mat_q, term_cur.z);
  end

  // The accumulator is cleared on the same edge that accepts a new operation.
  always_comb begin
    mac_clear  = (state == IDLE) && start;
    mac_en_mul = (state == MUL_A);
    mac_en_acc = (state == MUL_B);
  end

  det_mac #(
    .W  (W),
    .RW (RW)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (mac_clear),
    .en_mul (mac_en_mul),
    .en_acc (mac_en_acc),
    .sub    (term_cur.neg),
    .x      (x_sel),
    .y      (y_sel),
    .z      (z_sel),
    .acc    (acc)
  );

  // Range check and W-bit result derived from the final accumulator value.
  always_comb begin
    ovf   = (acc > MAX_POS) || (acc < MIN_NEG);
    res_w = acc[W-1:0];
`ifdef DET_SATURATE_EN
    if (ovf) begin
      res_w = acc[RW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

  // Control FSM. DONE lasts two cycles: the first lets the last accumulate
  // settle, the second (done already set) drives the pulse and then returns
  // to IDLE, dropping busy and done together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      k              <= '0;
      mat_q          <= '0;
      modo_q         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      resultado      <= '0;
      resultado_full <= '0;
      flag_overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mat_q  <= matriz;
            modo_q <= modo;
            k      <= '0;
            busy   <= 1'b1;
            state  <= MUL_A;
          end
        end
        MUL_A: begin
          state <= MUL_B;
        end
        MUL_B: begin
          if (k == last_term(modo_q)) begin
            state <= DONE;
          end else begin
            k     <= k + 3'd1;
            state <= MUL_A;
          end
        end
        DONE: begin
          if (!done) begin
            done           <= 1'b1;
            resultado_full <= acc;
            resultado      <= res_w;
            flag_overflow  <= ovf;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mod_det_seq.md
# mod_det_seq

Sequential, parameterised signed determinant engine for the arithmetic coprocessor. It computes det of a 2x2 or 3x3 matrix, selected per operation, with W-bit two's-complement elements. The block time-shares one signed multiplier across all products and keeps the full-precision result with an overflow flag. It sits beside the combinational determinant units and is driven by the coprocessor control FSM through a start/done handshake.

## Interface
- W, default 8: element width, signed two's complement, W ≥ 2.
- RW, default 3*W+1: full-precision result width (derived, never overridden).
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  requests an operation; sampled only in IDLE.
- modo  in  1  0 selects 2x2, 1 selects 3x3; sampled with start.
- matriz  in  9*W  elements a..i, row-major; a is at [W-1:0]. For 2x2, a b / d e are used and the rest are ignored.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when results are valid.
- resultado  out  W  W-bit result (wrapped or saturated, see Configuration).
- resultado_full  out  RW  exact signed determinant.
- flag_overflow  out  1  set when the exact result does not fit in signed W bits.

## Operation
- States: IDLE, MUL_A, MUL_B, DONE.
- IDLE to MUL_A: on start=1. The block captures matriz and modo, clears the accumulator, and sets the term index k=0.
- Term count T: 6 for 3x3, 2 for 2x2.
- 3x3 uses Sarrus terms, in this order: +aei, +bfg, +cdh, −ceg, −afh, −bdi.
- 2x2 terms, in order: +ae, −bd. The third factor is the constant 1.
- MUL_A: p ← x_k·y_k, where p is 2W bits signed. Then go to MUL_B.
- MUL_B: acc ← acc ± p·z_k, where acc is RW bits signed.
  - If k = T−1, go to DONE.
  - Otherwise increment k and go to MUL_A.
- DONE:
  - done=1 for exactly one cycle.
  - resultado_full, resultado and flag_overflow register from acc.
  - Return to IDLE.
- Overflow rule: flag_overflow = (acc > 2^(W−1)−1) or (acc < −2^(W−1)).
- All internal arithmetic is signed and sign-extended to RW bits. The accumulator never wraps, because RW bounds 6·2^(3W−3).

## Timing
- Reset: busy=0, done=0, resultado=0, resultado_full=0, flag_overflow=0, state=IDLE, and all internal registers are 0.
- Latency: done is high in the cycle starting 2T+1 edges after the edge that sampled start. This is 13 cycles for 3x3 and 5 for 2x2.
- busy rises on the edge that samples start. It falls on the edge leaving DONE, in the same edge that done falls.
- start while busy=1, including during DONE, is ignored and not queued.
- start held high continuously: a new operation is accepted in the IDLE cycle following DONE.
- matriz and modo may change freely after the sampling edge.
- Result outputs hold their value until the next DONE or reset.
- rst during any state returns the block to IDLE on that edge. All outputs go to reset values and no done is issued for the aborted operation.
- rst and start in the same cycle: rst wins, and the start is dropped.

## Configuration
- DET_SATURATE_EN defined: on overflow, resultado saturates to 2^(W−1)−1 or −2^(W−1) according to the sign of acc.
- DET_SATURATE_EN undefined: resultado = acc[W−1:0], i.e. it wraps, matching the existing combinational units.
- flag_overflow and resultado_full behave identically in both builds.

## Structure
- Shared package det_pkg holds:
  - the state encoding (IDLE, MUL_A, MUL_B, DONE);
  - the mode constants MODO_2X2 and MODO_3X3;
  - the Sarrus factor-index tables (x, y, z per term) and the per-term sign vectors for both modes;
  - the term counts.
- One sub-module, det_mac: a signed W×W multiply into a 2W-bit product register, plus a 2W×W multiply with add/subtract into the RW accumulator. It has clear and enable controls driven by the FSM.

## Test plan
- Identity 3x3 (a=e=i=1, others 0), modo=1 → done at cycle 13, resultado_full=1, resultado=1, flag_overflow=0.
- 2x2 [[3,5],[2,4]], modo=0 → done at cycle 5, resultado=2, flag_overflow=0.
- 3x3 [[2,−3,1],[2,0,−1],[1,4,5]] → resultado_full=49, resultado=49 (0x31), flag_overflow=0.
- W=8, diagonal (100,100,−100), others 0:
  - resultado_full=−1000000, flag_overflow=1;
  - resultado=0xC0 without DET_SATURATE_EN;
  - resultado=0x80 with DET_SATURATE_EN.
- Assert rst at cycle 6 of a 3x3 operation → busy=0 and outputs 0 on the next edge, no done pulse. A fresh start afterwards completes correctly in 13 cycles.
- Pulse start again at cycles 3 and 13 of a running operation → ignored. Exactly one done, and the result matches the first captured matrix.
